ecc_data_cache: RTL and testbench



---
 rtl/ecc_pkg.sv | 33 +++
 rtl/secded_encoder.sv | 11 +
 rtl/ecc_data_cache.sv | 111 +++++++++++
 tb/tb_ecc_data_cache.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared SEC-DED definitions: widths, stored-entry layout and the check-bit encoder.
// The load-stage detector reuses ecc_encode to build its syndrome.
package ecc_pkg;

   localparam int DATA_W = 32;
   localparam int PAR_W  = 7;

   typedef struct packed {
      logic [PAR_W-1:0]  par;
      logic [DATA_W-1:0] data;
   } entry_t;

   // Hamming positions 1..38; powers of two hold check bits, data fills the rest in order.
   function automatic logic [PAR_W-1:0] ecc_encode(input logic [DATA_W-1:0] d);
      logic [PAR_W-1:0] p;
      int               k;
      p = '0;
      k = 0;
      for (int pos = 1; pos <= 38; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            for (int i = 0; i < 6; i++) begin
               if (((pos >> i) & 1) != 0) begin
                  p[i[2:0]] = p[i[2:0]] ^ d[k[4:0]];
               end
            end
            k++;
         end
      end
      p[6] = (^d) ^ (^p[5:0]);
      return p;
   endfunction

endpackage

// File: rtl/secded_encoder.sv
// Combinational 32-bit to 7-bit SEC-DED check-bit generator; zero latency, no flow control.
module secded_encoder
   import ecc_pkg::*;
(
   input  logic [31:0] data,
   output logic [6:0]  parity
);

   assign parity = ecc_encode(data);

endmodule

// File: rtl/ecc_data_cache.sv
// ECC-protected word store: reads return {data, check bits} one cycle later; stores are never stalled.
// Scrub write-backs wait for a store-free edge and are dropped if a store hits the same word.
module ecc_data_cache
   import ecc_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [31:0]       wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [31:0]       data_Cache,
   output logic [6:0]        parity_Cache,
   output logic              rd_valid,
   input  logic              scrub_req,
   input  logic [31:0]       scrub_data,
   output logic              scrub_pending,
   output logic [7:0]        scrub_count
);

   entry_t            mem [DEPTH];
   entry_t            rd_q;
   logic              rd_valid_q;
   logic [ADDR_W-1:0] rd_addr_q;

   logic              pend_q;
   logic [ADDR_W-1:0] scrub_addr_q;
   logic [31:0]       scrub_data_q;
   logic [7:0]        count_q;

   logic [6:0]        wr_par;
   logic [6:0]        scrub_par;
   logic              capture;
   logic              commit;
   logic              drop;

   secded_encoder u_store_enc (
      .data   (wr_data),
      .parity (wr_par)
   );

   secded_encoder u_scrub_enc (
      .data   (scrub_data_q),
      .parity (scrub_par)
   );

   assign capture = scrub_req & rd_valid_q;
   assign commit  = pend_q & ~wr_en;
   // A store to the pending word is newer than the corrected copy, so the scrub is discarded.
   assign drop    = pend_q & wr_en & (wr_addr == scrub_addr_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_addr] <= '{par: wr_par, data: wr_data};
      end else if (commit) begin
         mem[scrub_addr_q] <= '{par: scrub_par, data: scrub_data_q};
      end
   end

   // Read sees the pre-edge array contents, giving read-first behaviour on address collisions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q       <= '0;
         rd_valid_q <= 1'b0;
         rd_addr_q  <= '0;
      end else begin
         rd_valid_q <= rd_en;
         if (rd_en) begin
            rd_q      <= mem[rd_addr];
            rd_addr_q <= rd_addr;
         end
      end
   end

   // Commit and drop act on the old pending entry; a same-edge capture replaces it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q       <= 1'b0;
         scrub_addr_q <= '0;
         scrub_data_q <= '0;
         count_q      <= '0;
      end else begin
         if (capture) begin
            pend_q       <= 1'b1;
            scrub_addr_q <= rd_addr_q;
            scrub_data_q <= scrub_data;
         end else if (commit || drop) begin
            pend_q <= 1'b0;
         end
         if (commit && (count_q != 8'hFF)) begin
            count_q <= count_q + 8'd1;
         end
      end
   end

   assign data_Cache    = rd_q.data;
   assign parity_Cache  = rd_q.par;
   assign rd_valid      = rd_valid_q;
   assign scrub_pending = pend_q;
   assign scrub_count   = count_q;

endmodule

// File: tb/tb_ecc_data_cache.sv
// Directed bench for ecc_data_cache: inputs change on the falling edge, outputs are sampled there too.
module tb_ecc_data_cache;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rd_en;
   logic [3:0]  rd_addr;
   logic [31:0] data_Cache;
   logic [6:0]  parity_Cache;
   logic        rd_valid;
   logic        scrub_req;
   logic [31:0] scrub_data;
   logic        scrub_pending;
   logic [7:0]  scrub_count;

   int total = 0;
   int bad   = 0;
   int exp_count = 0;

   always #5 clk = ~clk;

   ecc_data_cache #(.DEPTH(16), .ADDR_W(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .data_Cache    (data_Cache),
      .parity_Cache  (parity_Cache),
      .rd_valid      (rd_valid),
      .scrub_req     (scrub_req),
      .scrub_data    (scrub_data),
      .scrub_pending (scrub_pending),
      .scrub_count   (scrub_count)
   );

   // Check bits [5:0] equal the XOR of the Hamming positions of all set data bits.
   function automatic logic [6:0] model_par(input logic [31:0] d);
      logic [5:0] syn;
      int         pos;
      syn = '0;
      pos = 2;
      for (int b = 0; b < 32; b++) begin
         pos++;
         while ((pos & (pos - 1)) == 0) pos++;
         if (d[b]) syn = syn ^ pos[5:0];
      end
      return {(^d) ^ (^syn), syn};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = 0;
      scrub_req = 0; scrub_data = 0;
      repeat (2) @(negedge clk);
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%0b want=0", rd_valid); end
      total++; if (data_Cache !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", data_Cache); end
      total++; if (parity_Cache !== 7'h0) begin bad++; $display("FAIL reset_parity got=%h want=0", parity_Cache); end
      total++; if (scrub_pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%0b want=0", scrub_pending); end
      total++; if (scrub_count !== 8'h0) begin bad++; $display("FAIL reset_count got=%0d want=0", scrub_count); end
      rst_n = 1'b1;
      @(negedge clk); rd_en = 1; rd_addr = 4'd5;
      @(negedge clk); rd_en = 0;
      total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL read5_valid got=%0b want=1", rd_valid); end
      total++; if (data_Cache !== 32'h0) begin bad++; $display("FAIL read5_data got=%h want=0", data_Cache); end
      total++; if (parity_Cache !== 7'h00) begin bad++; $display("FAIL read5_parity got=%h want=00", parity_Cache); end
   endtask

   task automatic test_store_read();
      wr_en = 1; wr_addr = 4'd3; wr_data = 32'h0000_0001;
      @(negedge clk); wr_en = 0; rd_en = 1; rd_addr = 4'd3;
      @(negedge clk); rd_en = 0;
      total++; if (data_Cache !== 32'h0000_0001) begin bad++; $display("FAIL store3_data got=%h want=00000001", data_Cache); end
      total++; if (parity_Cache !== 7'h43) begin bad++; $display("FAIL store3_parity got=%h want=43", parity_Cache); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk); wr_en = 1; wr_addr = 4'd7; wr_data = 32'hAAAA_5555; rd_en = 1; rd_addr = 4'd7;
      @(negedge clk); wr_en = 0;
      total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL rfirst_valid got=%0b want=1", rd_valid); end
      total++; if (data_Cache !== 32'h0) begin bad++; $display("FAIL rfirst_old_data got=%h want=0", data_Cache); end
      total++; if (parity_Cache !== 7'h0) begin bad++; $display("FAIL rfirst_old_parity got=%h want=0", parity_Cache); end
      @(negedge clk); rd_addr = 4'd3;
      total++; if (data_Cache !== 32'hAAAA_5555) begin bad++; $display("FAIL rfirst_new_data got=%h want=aaaa5555", data_Cache); end
      total++; if (parity_Cache !== model_par(32'hAAAA_5555)) begin bad++; $display("FAIL rfirst_new_parity got=%h want=%h", parity_Cache, model_par(32'hAAAA_5555)); end
      @(negedge clk); rd_en = 0;
      total++; if (data_Cache !== 32'h0000_0001) begin bad++; $display("FAIL b2b_data got=%h want=00000001", data_Cache); end
      @(negedge clk);
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%0b want=0", rd_valid); end
      total++; if (data_Cache !== 32'h0000_0001) begin bad++; $display("FAIL idle_hold_data got=%h want=00000001", data_Cache); end
      total++; if (parity_Cache !== 7'h43) begin bad++; $display("FAIL idle_hold_parity got=%h want=43", parity_Cache); end
   endtask

   task automatic test_scrub_ignore();
      scrub_req = 1; scrub_data = 32'hBAD0_BAD0;
      @(negedge clk); scrub_req = 0;
      total++; if (scrub_pending !== 1'b0) begin bad++; $display("FAIL ignore_pending got=%0b want=0", scrub_pending); end
      @(negedge clk);
      total++; if (scrub_count !== 8'd0) begin bad++; $display("FAIL ignore_count got=%0d want=0", scrub_count); end
   endtask

   task automatic test_scrub_commit();
      wr_en = 1; wr_addr = 4'd2; wr_data = 32'h1234_5678;
      @(negedge clk); wr_en = 0; rd_en = 1; rd_addr = 4'd2;
      @(negedge clk); rd_en = 0; scrub_req = 1; scrub_data = 32'h1234_5678;
      total++; if (data_Cache !== 32'h1234_5678) begin bad++; $display("FAIL scrub_rd_data got=%h want=12345678", data_Cache); end
      @(negedge clk); scrub_req = 0;
      total++; if (scrub_pending !== 1'b1) begin bad++; $display("FAIL scrub_capture got=%0b want=1", scrub_pending); end
      total++; if (scrub_count !== 8'd0) begin bad++; $display("FAIL scrub_precount got=%0d want=0", scrub_count); end
      @(negedge clk); rd_en = 1; rd_addr = 4'd2;
      total++; if (scrub_pending !== 1'b0) begin bad++; $display("FAIL scrub_commit_pending got=%0b want=0", scrub_pending); end
      total++; if (scrub_count !== 8'd1) begin bad++; $display("FAIL scrub_commit_count got=%0d want=1", scrub_count); end
      @(negedge clk); rd_en = 0;
      total++; if (data_Cache !== 32'h1234_5678) begin bad++; $display("FAIL scrub_reread_data got=%h want=12345678", data_Cache); end
      total++; if (parity_Cache !== model_par(32'h1234_5678)) begin bad++; $display("FAIL scrub_reread_parity got=%h want=%h", parity_Cache, model_par(32'h1234_5678)); end
   endtask

   task automatic test_scrub_wait_store();
      rd_en = 1; rd_addr = 4'd2;
      @(negedge clk); rd_en = 0; scrub_req = 1; scrub_data = 32'hCAFE_0002;
      wr_en = 1; wr_addr = 4'd9; wr_data = 32'h0909_0909;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); scrub_req = 0;
         total++; if (scrub_pending !== 1'b1) begin bad++; $display("FAIL wait_pending cyc=%0d got=%0b want=1", i, scrub_pending); end
      end
      wr_en = 0;
      total++; if (scrub_count !== 8'd1) begin bad++; $display("FAIL wait_count got=%0d want=1", scrub_count); end
      @(negedge clk); rd_en = 1; rd_addr = 4'd2;
      total++; if (scrub_pending !== 1'b0) begin bad++; $display("FAIL wait_commit_pending got=%0b want=0", scrub_pending); end
      total++; if (scrub_count !== 8'd2) begin bad++; $display("FAIL wait_commit_count got=%0d want=2", scrub_count); end
      @(negedge clk); rd_addr = 4'd9;
      total++; if (data_Cache !== 32'hCAFE_0002) begin bad++; $display("FAIL wait_scrub_data got=%h want=cafe0002", data_Cache); end
      total++; if (parity_Cache !== model_par(32'hCAFE_0002)) begin bad++; $display("FAIL wait_scrub_parity got=%h want=%h", parity_Cache, model_par(32'hCAFE_0002)); end
      @(negedge clk); rd_en = 0;
      total++; if (data_Cache !== 32'h0909_0909) begin bad++; $display("FAIL wait_store_data got=%h want=09090909", data_Cache); end
   endtask

   task automatic test_scrub_drop();
      rd_en = 1; rd_addr = 4'd2;
      @(negedge clk); rd_en = 0; scrub_req = 1; scrub_data = 32'hDEAD_0002;
      @(negedge clk); scrub_req = 0; wr_en = 1; wr_addr = 4'd2; wr_data = 32'h5A5A_0002;
      total++; if (scrub_pending !== 1'b1) begin bad++; $display("FAIL drop_capture got=%0b want=1", scrub_pending); end
      @(negedge clk); wr_en = 0;
      total++; if (scrub_pending !== 1'b0) begin bad++; $display("FAIL drop_pending got=%0b want=0", scrub_pending); end
      @(negedge clk); rd_en = 1; rd_addr = 4'd2;
      total++; if (scrub_count !== 8'd2) begin bad++; $display("FAIL drop_count got=%0d want=2", scrub_count); end
      @(negedge clk); rd_en = 0;
      total++; if (data_Cache !== 32'h5A5A_0002) begin bad++; $display("FAIL drop_data got=%h want=5a5a0002", data_Cache); end
      total++; if (parity_Cache !== model_par(32'h5A5A_0002)) begin bad++; $display("FAIL drop_parity got=%h want=%h", parity_Cache, model_par(32'h5A5A_0002)); end
   endtask

   task automatic test_saturate();
      logic m_rv;
      logic m_pend;
      logic seen254;
      m_rv = 0; m_pend = 0; seen254 = 0;
      exp_count = 2;
      @(negedge clk); rd_en = 1; rd_addr = 4'd4; scrub_req = 1; scrub_data = 32'hF0F0_1234;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         if (m_pend && exp_count < 255) exp_count++;
         m_pend = m_rv;
         m_rv   = 1'b1;
         @(negedge clk);
         if (exp_count == 254 && !seen254) begin
            seen254 = 1;
            total++; if (scrub_count !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d want=254", scrub_count); end
         end
      end
      rd_en = 0; scrub_req = 0;
      @(negedge clk); rd_en = 1; rd_addr = 4'd4;
      total++; if (scrub_pending !== 1'b0) begin bad++; $display("FAIL sat_pending got=%0b want=0", scrub_pending); end
      total++; if (scrub_count !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d want=255", scrub_count); end
      @(negedge clk); rd_en = 0;
      total++; if (data_Cache !== 32'hF0F0_1234) begin bad++; $display("FAIL sat_data got=%h want=f0f01234", data_Cache); end
      total++; if (parity_Cache !== model_par(32'hF0F0_1234)) begin bad++; $display("FAIL sat_parity got=%h want=%h", parity_Cache, model_par(32'hF0F0_1234)); end
   endtask

   task automatic test_reset_mid();
      rd_en = 1; rd_addr = 4'd4;
      @(negedge clk); scrub_req = 1; scrub_data = 32'h1111_1111;
      wr_en = 1; wr_addr = 4'd11; wr_data = 32'h2222_2222;
      @(negedge clk);
      total++; if (scrub_pending !== 1'b1) begin bad++; $display("FAIL rmid_pre_pending got=%0b want=1", scrub_pending); end
      total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid got=%0b want=1", rd_valid); end
      rst_n = 0;
      #1;
      total++; if (scrub_pending !== 1'b0) begin bad++; $display("FAIL rmid_pending got=%0b want=0", scrub_pending); end
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0b want=0", rd_valid); end
      total++; if (scrub_count !== 8'd0) begin bad++; $display("FAIL rmid_count got=%0d want=0", scrub_count); end
      total++; if (data_Cache !== 32'h0) begin bad++; $display("FAIL rmid_data got=%h want=0", data_Cache); end
      rd_en = 0; wr_en = 0; scrub_req = 0;
      @(negedge clk); @(negedge clk); rst_n = 1;
      @(negedge clk); rd_en = 1; rd_addr = 4'd3;
      @(negedge clk); rd_en = 0;
      total++; if (data_Cache !== 32'h0) begin bad++; $display("FAIL rmid_array_data got=%h want=0", data_Cache); end
      total++; if (parity_Cache !== 7'h0) begin bad++; $display("FAIL rmid_array_parity got=%h want=0", parity_Cache); end
      total++; if (scrub_count !== 8'd0) begin bad++; $display("FAIL rmid_post_count got=%0d want=0", scrub_count); end
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_store_read();
      test_back_to_back();
      test_scrub_ignore();
      test_scrub_commit();
      test_scrub_wait_store();
      test_scrub_drop();
      test_saturate();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
